// File: rtl/divider_unit_if.sv
// ---------------------------------------------------------------------------
// divider_unit_if
//   Start/busy/done handshake between the pipeline controller and the
//   multi-cycle divider.
//   master (controller): drives start, sgn, a, b; observes busy, done,
//                        lo, hi, div_zero.
//   slave  (divider)   : the reverse.
//   WIDTH sets the operand and result width.
// ---------------------------------------------------------------------------
interface divider_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             div_zero;

  modport master (
    output start, sgn, a, b,
    input  busy, done, lo, hi, div_zero
  );

  modport slave (
    input  start, sgn, a, b,
    output busy, done, lo, hi, div_zero
  );
endinterface

// File: rtl/divider_unit.sv
// ---------------------------------------------------------------------------
// divider_unit
//   Multi-cycle restoring shift-subtract divider for DIV (signed) and DIVU
//   (unsigned). One quotient bit per cycle. The quotient goes to lo and the
//   remainder to hi, following the HI/LO convention of the multiplier.
//
//   Ports:
//     clk    - single clock, rising edge
//     reset  - synchronous, active-high
//     bus    - divider_unit_if.slave:
//                start/sgn/a/b in  : request, captured only while idle
//                busy          out : operation in progress (CALC or FIX)
//                done          out : one-cycle pulse when results update
//                lo/hi         out : quotient / remainder
//                div_zero      out : last completed operation had b == 0
//
//   Timing: a nonzero-divisor request sampled at edge k finishes at edge
//   k+33; a zero-divisor request finishes at edge k+1.
// ---------------------------------------------------------------------------
module divider_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  divider_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [WIDTH-1:0] rem_q,      rem_d;      // partial remainder
  logic [WIDTH-1:0] quo_q,      quo_d;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q,      dvs_d;      // divisor magnitude
  logic             qneg_q,     qneg_d;     // negate quotient in FIX
  logic             rneg_q,     rneg_d;     // negate remainder in FIX
  logic             dz_q,       dz_d;       // current operation divides by zero
  logic [WIDTH-1:0] lo_q,       lo_d;
  logic [WIDTH-1:0] hi_q,       hi_d;
  logic             done_q,     done_d;
  logic             div_zero_q, div_zero_d;

  // Operand magnitudes. The sign flags are already gated by sgn, so DIVU
  // passes the raw operands through untouched.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Trial subtraction on the shifted remainder. The extra top bit is the
  // borrow: set means the divisor did not fit and the old value is kept.
  logic [WIDTH:0]   trial;

  always_comb begin
    a_neg = bus.sgn & bus.a[WIDTH-1];
    b_neg = bus.sgn & bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  end

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          rem_d  = '0;
          cnt_d  = CW'(WIDTH);
          dvs_d  = b_mag;
          if (bus.b == '0) begin
            // No iterations: keep the untouched dividend so FIX can
            // return it as the remainder.
            dz_d    = 1'b1;
            quo_d   = bus.a;
            state_d = FIX;
          end else begin
            dz_d    = 1'b0;
            quo_d   = a_mag;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (dz_q) begin
          lo_d = '1;
          hi_d = quo_q;
        end else begin
          // 0x80000000 / -1 yields magnitude 0x80000000 with a positive
          // quotient sign, which is exactly the wrapped result wanted.
          lo_d = qneg_q ? -quo_q : quo_q;
          hi_d = rneg_q ? -rem_q : rem_q;
        end
        div_zero_d = dz_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  // busy covers CALC and FIX; done is registered in FIX, when the state has
  // already returned to IDLE, so the two are never high together.
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.lo       = lo_q;
  assign bus.hi       = hi_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_divider_unit.sv
// ---------------------------------------------------------------------------
// tb_divider_unit
//   Self-checking bench for divider_unit. A transaction-level model predicts
//   busy/done/lo/hi/div_zero every cycle from plain arithmetic; directed
//   cases pin hand-computed results and latencies, then random operations
//   run against the model.
// ---------------------------------------------------------------------------
module tb_divider_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  divider_unit_if #(.WIDTH(32)) bus ();

  divider_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit seen_rst = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result {div_zero, hi, lo} from the arithmetic rules.
  function automatic logic [64:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
    return {1'b0, r, q};
  endfunction

  // Transaction model: remaining cycles of the current operation, the
  // pending result, and the currently visible outputs.
  int          m_cnt  = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_lo   = '0;
  logic [31:0] m_hi   = '0;
  bit          m_dz   = 1'b0;
  logic [64:0] p_res  = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      seen_rst <= 1'b1;
      m_cnt    <= 0;
      m_done   <= 1'b0;
      m_lo     <= '0;
      m_hi     <= '0;
      m_dz     <= 1'b0;
    end else if (m_cnt == 0) begin
      m_done <= 1'b0;
      if (bus.start) begin
        p_res <= ref_div(bus.sgn, bus.a, bus.b);
        m_cnt <= (bus.b == 32'd0) ? 1 : 33;
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_lo   <= p_res[31:0];
        m_hi   <= p_res[63:32];
        m_dz   <= p_res[64];
        m_done <= 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (seen_rst) begin
      check("busy",     64'(bus.busy),     64'(m_cnt != 0));
      check("done",     64'(bus.done),     64'(m_done));
      check("lo",       64'(bus.lo),       64'(m_lo));
      check("hi",       64'(bus.hi),       64'(m_hi));
      check("div_zero", 64'(bus.div_zero), 64'(m_dz));
    end
  end

  // Issue one request at the current negedge and wait for done. Returns the
  // latency in clock edges from the sampling edge and the busy cycle count.
  // poke_at > 0 pulses a 20/3 start at that cycle of the operation.
  task automatic run_op(input logic s, input logic [31:0] av, input logic [31:0] bv,
                        input int poke_at, output int lat, output int busy_cnt);
    int kedge;
    bit got;
    got       = 1'b0;
    lat       = -1;
    busy_cnt  = 0;
    bus.start = 1'b1;
    bus.sgn   = s;
    bus.a     = av;
    bus.b     = bv;
    kedge     = cyc + 1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.start = 1'b0;
        bus.sgn   = 1'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
      if (poke_at > 0 && i == poke_at - 1) begin
        bus.start = 1'b1;
        bus.sgn   = 1'b0;
        bus.a     = 32'd20;
        bus.b     = 32'd3;
      end
      if (poke_at > 0 && i == poke_at) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        got = 1'b1;
        lat = cyc - kedge;
      end
    end
    check("done_seen", 64'(got), 64'd1);
  endtask

  task automatic expect_res(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                            input logic dz);
    check({tag, "_lo"}, 64'(bus.lo), 64'(lo));
    check({tag, "_hi"}, 64'(bus.hi), 64'(hi));
    check({tag, "_dz"}, 64'(bus.div_zero), 64'(dz));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bc;
    bit saw_done;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    expect_res("rst", 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Unsigned 100 / 7.
    run_op(1'b0, 32'd100, 32'd7, 0, lat, bc);
    check("u100_7_lat", 64'(lat), 64'd33);
    check("u100_7_busy", 64'(bc), 64'd33);
    expect_res("u100_7", 32'd14, 32'd2, 1'b0);
    @(negedge clk);

    // Signed, negative dividend.
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, bc);
    expect_res("sm7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, lat, bc);
    expect_res("sm7_m2", 32'd3, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);

    // Divide by zero, then a normal op clears div_zero.
    run_op(1'b1, 32'h1234_5678, 32'd0, 0, lat, bc);
    check("dz_lat", 64'(lat), 64'd1);
    expect_res("dz", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    @(negedge clk);
    run_op(1'b0, 32'd10, 32'd5, 0, lat, bc);
    expect_res("u10_5", 32'd2, 32'd0, 1'b0);
    @(negedge clk);

    // Signed overflow and large unsigned operands.
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bc);
    expect_res("ovf", 32'h8000_0000, 32'd0, 1'b0);
    @(negedge clk);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h10, 0, lat, bc);
    expect_res("uffff_10", 32'h0FFF_FFFF, 32'hF, 1'b0);
    @(negedge clk);

    // start while busy is ignored.
    run_op(1'b0, 32'd100, 32'd7, 10, lat, bc);
    check("poke_lat", 64'(lat), 64'd33);
    expect_res("poke", 32'd14, 32'd2, 1'b0);
    @(negedge clk);

    // start in the done cycle is accepted with no dead cycle.
    run_op(1'b0, 32'd100, 32'd7, 0, lat, bc);
    run_op(1'b0, 32'd20, 32'd3, 0, lat, bc);
    check("b2b_lat", 64'(lat), 64'd33);
    expect_res("b2b", 32'd6, 32'd2, 1'b0);
    @(negedge clk);

    // Reset mid-operation.
    bus.start = 1'b1;
    bus.sgn   = 1'b0;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_busy", 64'(bus.busy), 64'd0);
    check("mrst_done", 64'(bus.done), 64'd0);
    expect_res("mrst", 32'd0, 32'd0, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("mrst_no_done", 64'(saw_done), 64'd0);
    run_op(1'b0, 32'd9, 32'd3, 0, lat, bc);
    expect_res("u9_3", 32'd3, 32'd0, 1'b0);
    @(negedge clk);

    // reset and start together: reset wins.
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.a     = 32'd9;
    bus.b     = 32'd3;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    check("rst_start_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("rst_start_busy2", 64'(bus.busy), 64'd0);

    // Random operations against the model.
    for (int n = 0; n < 200; n++) begin
      logic        rs;
      logic [31:0] ra;
      logic [31:0] rb;
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 16);
        3:       rb = 32'($urandom) >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(rs, ra, rb, 0, lat, bc);
      check("rnd_lat", 64'(lat), (rb == 32'd0) ? 64'd1 : 64'd33);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
